// File: rtl/ifetch_queue.sv
// Instruction fetch front end: issues sequential fetch addresses to imem, buffers the
// returned words in order, and hands {pc, word} to decode; a redirect flushes and restarts.
module ifetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   output logic [63:0] imem_addr,
   output logic        imem_addr_valid,
   input  logic [63:0] imem_data,
   input  logic        imem_data_valid,
   output logic [63:0] inst_word,
   output logic [63:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [1:0]  dbg_state
);

   // Handshake: a word moves to decode in any cycle where inst_valid and inst_ready are
   // both high at the rising edge; inst_valid never depends on inst_ready, and the head
   // {inst_pc, inst_word} stays put while inst_valid is high and inst_ready is low.

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [63:0]   fetch_pc, resp_pc, redirect_base;
   logic [CW-1:0] count, outstanding, outstanding_nxt;
   logic [CW:0]   in_use;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [63:0]   fifo_pc   [DEPTH];
   logic [63:0]   fifo_word [DEPTH];
   logic          do_redirect, issue, beat, push, pop;

   assign redirect_base = redirect_pc & ~64'h7;
   assign in_use        = {1'b0, count} + {1'b0, outstanding};

   assign inst_valid      = (state == RUN) && (count != '0);
   assign inst_word       = fifo_word[rd_ptr];
   assign inst_pc         = fifo_pc[rd_ptr];
   assign imem_addr_valid = issue;
   assign imem_addr       = (state == BOOT) ? 64'h0 : fetch_pc;
   assign dbg_state       = state;

   // Beats with nothing outstanding are protocol errors and leave every counter alone.
   always_comb begin
      do_redirect     = redirect && (state != BOOT);
      issue           = (state == RUN) && !redirect && (in_use < DEPTH_C);
      beat            = imem_data_valid && (outstanding != '0);
      push            = beat && (state == RUN) && !redirect;
      pop             = inst_valid && inst_ready && !redirect;
      outstanding_nxt = outstanding + CW'(issue) - CW'(beat);
      state_nxt       = state;
      case (state)
         BOOT:    state_nxt = RUN;
         RUN:     if (redirect && (outstanding_nxt != '0)) state_nxt = FLUSH;
         FLUSH:   if (!redirect && (outstanding_nxt == '0)) state_nxt = RUN;
         default: state_nxt = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BOOT;
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         state       <= state_nxt;
         outstanding <= outstanding_nxt;
         if (do_redirect) begin
            fetch_pc <= redirect_base;
            resp_pc  <= redirect_base;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
         end else begin
            if (issue) fetch_pc <= fetch_pc + 64'd8;
            if (push) begin
               resp_pc <= resp_pc + 64'd8;
               wr_ptr  <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: ;
            endcase
         end
      end
   end

   // Storage is cleared on reset so the head outputs read zero until the first push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_pc[i]   <= '0;
            fifo_word[i] <= '0;
         end
      end else if (push) begin
         fifo_pc[wr_ptr]   <= resp_pc;
         fifo_word[wr_ptr] <= imem_data;
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: a variable-latency imem model feeds an expected queue of
// {pc, word} pairs that is checked against every word decode accepts.
module tb_ifetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [63:0] RESET_PC = 64'h0;

   logic        clk, rst_n, redirect, imem_addr_valid, imem_data_valid, inst_valid, inst_ready;
   logic [63:0] redirect_pc, imem_addr, imem_data, inst_word, inst_pc;
   logic [1:0]  dbg_state;

   ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .imem_addr       (imem_addr),
      .imem_addr_valid (imem_addr_valid),
      .imem_data       (imem_data),
      .imem_data_valid (imem_data_valid),
      .inst_word       (inst_word),
      .inst_pc         (inst_pc),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .dbg_state       (dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [63:0] addr;
      logic [63:0] data;
      int          due;
      int          epoch;
   } req_t;

   req_t         pending[$];
   logic [127:0] exp_q[$];
   logic [63:0]  exp_fetch_pc, word_xor, first_pc;
   int           n_vec, n_err, cyc, last_due, model_out, epoch;
   int           ready_pct, dmin, dmax, pops, issues;
   bit           want_first;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // imem model plus scoreboard update for one clock
   task automatic cycle(input bit do_redir, input logic [63:0] rpc);
      bit           deliver;
      int           d;
      req_t         r;
      logic [127:0] e;
      @(negedge clk);
      redirect        = do_redir;
      redirect_pc     = rpc;
      inst_ready      = (int'($urandom_range(99)) < ready_pct);
      deliver         = (pending.size() > 0) && (pending[0].due <= cyc);
      imem_data_valid = deliver;
      imem_data       = deliver ? pending[0].data : {$urandom, $urandom};
      #1;
      check_eq("inst_valid", inst_valid, exp_q.size() != 0);
      if (do_redir) check_eq("no_req_on_redirect", imem_addr_valid, 1'b0);
      if (imem_addr_valid) begin
         issues++;
         check_eq("req_addr", imem_addr, exp_fetch_pc);
         check_eq("req_room", (model_out + exp_q.size()) < DEPTH, 1'b1);
      end
      if (inst_valid && inst_ready && !do_redir) begin
         pops++;
         check_eq("pop_has_entry", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("inst_pc", inst_pc, e[127:64]);
            check_eq("inst_word", inst_word, e[63:0]);
            if (want_first) begin
               first_pc   = inst_pc;
               want_first = 1'b0;
            end
         end
      end
      if (deliver) begin
         r = pending.pop_front();
         model_out--;
         if (r.epoch == epoch && !do_redir) exp_q.push_back({r.addr, r.data});
      end
      if (imem_addr_valid) begin
         d       = int'($urandom_range(dmax, dmin));
         r.addr  = imem_addr;
         r.data  = imem_addr ^ word_xor;
         r.due   = (cyc + d > last_due) ? cyc + d : last_due + 1;
         r.epoch = epoch;
         last_due = r.due;
         pending.push_back(r);
         model_out++;
         exp_fetch_pc = exp_fetch_pc + 64'd8;
      end
      if (do_redir) begin
         epoch++;
         exp_q.delete();
         exp_fetch_pc = rpc & ~64'h7;
      end
      cyc++;
   endtask

   // Asserts reset mid-cycle, then releases it with one stale beat presented in BOOT.
   task automatic do_reset();
      @(negedge clk);
      rst_n           = 1'b0;
      redirect        = 1'b0;
      imem_data_valid = 1'b0;
      inst_ready      = 1'b0;
      #1;
      check_eq("rst_addr_valid", imem_addr_valid, 1'b0);
      check_eq("rst_addr", imem_addr, 64'h0);
      check_eq("rst_inst_valid", inst_valid, 1'b0);
      check_eq("rst_inst_word", inst_word, 64'h0);
      check_eq("rst_inst_pc", inst_pc, 64'h0);
      check_eq("rst_state", dbg_state, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;
      if (pending.size() > 0) begin
         imem_data_valid = 1'b1;
         imem_data       = pending[0].data;
      end
      pending.delete();
      exp_q.delete();
      model_out    = 0;
      exp_fetch_pc = RESET_PC;
      epoch++;
      #1;
      check_eq("boot_addr_valid", imem_addr_valid, 1'b0);
      check_eq("boot_inst_valid", inst_valid, 1'b0);
   endtask

   task automatic start_phase();
      pops       = 0;
      issues     = 0;
      want_first = 1'b1;
      first_pc   = '1;
   endtask

   initial begin
      n_vec = 0; n_err = 0; cyc = 0; last_due = 0; model_out = 0; epoch = 0;
      rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_data = '0;
      imem_data_valid = 1'b0; inst_ready = 1'b0; word_xor = '0;
      exp_fetch_pc = RESET_PC;

      // sequential fetch from reset, word = addr, 1-cycle RAM
      ready_pct = 100; dmin = 1; dmax = 1;
      do_reset();
      start_phase();
      repeat (20) cycle(1'b0, 64'h0);
      check_eq("t1_first_pc", first_pc, RESET_PC);
      check_eq("t1_throughput", pops >= 15, 1'b1);

      // decode stalled: fetch must stop at DEPTH words, then drain in order
      ready_pct = 0;
      do_reset();
      start_phase();
      repeat (10) cycle(1'b0, 64'h0);
      check_eq("t2_issues", issues, 4);
      check_eq("t2_addr_valid_low", imem_addr_valid, 1'b0);
      ready_pct = 100;
      start_phase();
      repeat (10) cycle(1'b0, 64'h0);
      check_eq("t2_first_pc", first_pc, RESET_PC);
      check_eq("t2_drain", pops >= 4, 1'b1);

      // redirect with beats in flight: FLUSH, then resume at the aligned target
      word_xor = 64'hC0DE_0000_0000_0000;
      dmin = 2; dmax = 2;
      repeat (10) cycle(1'b0, 64'h0);
      cycle(1'b1, 64'h1007);
      @(posedge clk);
      #1;
      check_eq("t3_flush_state", dbg_state, 2'd2);
      start_phase();
      repeat (20) cycle(1'b0, 64'h0);
      check_eq("t3_first_pc", first_pc, 64'h1000);
      check_eq("t3_resume", pops >= 5, 1'b1);

      // address wrap past 2^64
      dmin = 1; dmax = 2;
      cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
      start_phase();
      repeat (20) cycle(1'b0, 64'h0);
      check_eq("t4_first_pc", first_pc, 64'hFFFF_FFFF_FFFF_FFF8);
      check_eq("t4_resume", pops >= 5, 1'b1);

      // random backpressure, latency and redirects
      ready_pct = 60; dmin = 1; dmax = 3;
      start_phase();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(49) == 0) cycle(1'b1, {$urandom, $urandom});
         else cycle(1'b0, 64'h0);
      end
      check_eq("t5_progress", pops >= 200, 1'b1);

      // reset with responses outstanding
      ready_pct = 100; dmin = 3; dmax = 3;
      repeat (10) cycle(1'b0, 64'h0);
      for (int i = 0; i < 20 && model_out < 2; i++) cycle(1'b0, 64'h0);
      do_reset();
      start_phase();
      repeat (15) cycle(1'b0, 64'h0);
      check_eq("t6_first_pc", first_pc, RESET_PC);
      check_eq("t6_resume", pops >= 3, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
